ecg_sample_fetch: RTL
=====================

ECG_SAMPLE_FETCH -- requirements
Module: ecg_sample_fetch

Interface
REQ-001 Parameters: DATA_WIDTH, default 11, ECG sample width; CTR_WIDTH, default 24, sample index width; DIV_WIDTH, default 16, rate divider width; FIFO_DEPTH, default 8, output buffer entries (power of 2, >=2).
REQ-002 Ports, one per line, shall be exactly:
- clk  in  1  single clock, all state on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- enable  in  1  run/stop request.
- rate_div  in  DIV_WIDTH  sample period minus one, in clk cycles.
- signal_req  out  1  one-cycle sample request to the upstream recording source.
- signal_in  in  DATA_WIDTH  sample from the source.
- signal_in_valid  in  1  signal_in qualifier.
- sample_out  out  DATA_WIDTH  FIFO head sample to the algorithm core.
- sample_idx  out  CTR_WIDTH  index of the FIFO head sample.
- sample_valid  out  1  FIFO head valid.
- sample_ready  in  1  consumer accepts head.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: a tick was dropped because the FIFO was full.
- timeout  out  1  sticky: a request got no response.

Function
REQ-003 Prescaler shall count 0..rate_div while enable=1 and emit a tick when count==rate_div, then reload 0; one tick every rate_div+1 cycles; rate_div=0 yields a tick every cycle.
REQ-004 Prescaler shall hold at 0 while enable=0; a rate_div change takes effect at the next reload.
REQ-005 FSM states shall be IDLE, WAIT_TICK, REQ, WAIT_DATA.
REQ-006 IDLE -> WAIT_TICK when enable=1; WAIT_TICK -> IDLE when enable=0.
REQ-007 WAIT_TICK on tick: if fifo_count<FIFO_DEPTH -> REQ; else stay, no request, set overflow.
REQ-008 In REQ, signal_req shall be 1 for exactly that one cycle, then -> WAIT_DATA; signal_req shall be 0 in every other state.
REQ-009 signal_in_valid=1 in REQ or WAIT_DATA shall push {signal_in, sample_index} into the FIFO, increment sample_index by 1, and the FSM shall -> WAIT_TICK, or -> IDLE if enable=0.
REQ-010 WAIT_DATA shall time out after 16 cycles without valid: set timeout, no push, index unchanged, -> WAIT_TICK (or IDLE if enable=0).
REQ-011 signal_in_valid in IDLE or WAIT_TICK shall be ignored: no push, no flag.
REQ-012 Only one request outstanding at any time; further ticks during REQ/WAIT_DATA shall be discarded without setting overflow.
REQ-013 sample_index shall wrap from 2^CTR_WIDTH-1 to 0 without a flag.
REQ-014 FIFO shall be first-word-fall-through: sample_valid = (fifo_count!=0); sample_out/sample_idx show the head combinationally from storage.
REQ-015 Pop occurs when sample_valid & sample_ready; pop with empty FIFO is a no-op.
REQ-016 Simultaneous push and pop shall leave fifo_count unchanged and preserve order; a push can never occur when full (REQ-007 guarantees space).
REQ-017 sample_out/sample_idx shall be stable while sample_valid=1 and sample_ready=0.
REQ-018 overflow and timeout shall remain set until reset.

Reset
REQ-019 nrst=0 shall immediately force: FSM IDLE, prescaler 0, sample_index 0, FIFO empty (fifo_count 0, sample_valid 0), signal_req 0, overflow 0, timeout 0, sample_out 0, sample_idx 0.
REQ-020 Reset asserted mid-request shall discard the in-flight request; a valid arriving after release while in IDLE shall be ignored.

Verification
REQ-021 rate_div=9, enable=1, source answers 1 cycle after req with 100,101,102; sample_ready=1 -> signal_req every 10 cycles; outputs (100,0),(101,1),(102,2) in order.
REQ-022 rate_div=0, sample_ready=0, FIFO_DEPTH=8 -> 8 pushes, fifo_count=8, then no signal_req and overflow=1; raising sample_ready drains idx 0..7 in order.
REQ-023 Source never answers -> timeout=1 exactly 16 cycles after REQ exits; next tick issues a new request; index stays 0.
REQ-024 FIFO at count 3, push and pop on the same cycle -> count stays 3, head advances by one index.
REQ-025 nrst pulsed low while in WAIT_DATA with 4 entries buffered -> all outputs reach reset values immediately; late valid ignored; first post-reset sample gets idx 0.
REQ-026 Preload sample_index near wrap (force index 2^24-2) -> consecutive outputs idx 16777214, 16777215, 0.

Source files
------------

// File: rtl/ecg_sample_fetch.sv
// ECG sample fetcher: a rate prescaler paces one-at-a-time sample requests to the
// recording source, and the returned samples are tagged with a running index and buffered in a FWFT FIFO.
module ecg_sample_fetch #(
  parameter int DATA_WIDTH = 11,
  parameter int CTR_WIDTH  = 24,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  output logic                          signal_req,
  input  logic [DATA_WIDTH-1:0]         signal_in,
  input  logic                          signal_in_valid,
  output logic [DATA_WIDTH-1:0]         sample_out,
  output logic [CTR_WIDTH-1:0]          sample_idx,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    WAIT_LAST  = 4'd15;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, REQ, WAIT_DATA} state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q, presc_d;
  logic [DIV_WIDTH-1:0]   period_q, period_d;
  logic [DIV_WIDTH-1:0]   eff_div;
  logic                   tick;
  logic [3:0]             wait_q, wait_d;
  logic [CTR_WIDTH-1:0]   sample_index_q, sample_index_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   push, pop;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DATA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [CTR_WIDTH-1:0]   mem_idx  [FIFO_DEPTH];

  // rate_div is sampled only at the reload point (count 0) so a change never
  // truncates or stretches the period already in progress.
  always_comb begin
    eff_div  = (presc_q == '0) ? rate_div : period_q;
    tick     = enable && (presc_q == eff_div);
    period_d = eff_div;
    presc_d  = presc_q;
    if (!enable || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + DIV_WIDTH'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    sample_index_d = sample_index_q;
    overflow_d     = overflow_q;
    timeout_d      = timeout_q;
    push           = 1'b0;
    signal_req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          if (count_q != FULL_COUNT) state_d = REQ;
          else                       overflow_d = 1'b1;
        end
      end
      REQ: begin
        signal_req = 1'b1;
        wait_d     = '0;
        if (signal_in_valid) begin
          push           = 1'b1;
          sample_index_d = sample_index_q + CTR_WIDTH'(1);
          state_d        = enable ? WAIT_TICK : IDLE;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (signal_in_valid) begin
          push           = 1'b1;
          sample_index_d = sample_index_q + CTR_WIDTH'(1);
          state_d        = enable ? WAIT_TICK : IDLE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = enable ? WAIT_TICK : IDLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push only ever happens with space available, so no full guard is needed here.
  always_comb begin
    pop      = sample_valid && sample_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      period_q       <= '0;
      wait_q         <= '0;
      sample_index_q <= '0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      period_q       <= period_d;
      wait_q         <= wait_d;
      sample_index_q <= sample_index_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= signal_in;
      mem_idx[wr_ptr_q]  <= sample_index_q;
    end
  end

  // Head is masked to zero while empty so reset shows zeros without clearing storage.
  assign sample_valid = (count_q != '0);
  assign sample_out   = sample_valid ? mem_data[rd_ptr_q] : '0;
  assign sample_idx   = sample_valid ? mem_idx[rd_ptr_q]  : '0;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;

endmodule
